i_cache_refill_ctrl: RTL and testbench
======================================

I_CACHE_REFILL_CTRL -- requirements
Module: i_cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH_DATA, default 32, word width; NUMBER_WORD, default 8, words per cache line; WIDTH_ADD, default 32, address width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Miss_Req  input  1  read-miss request from cache control; held high until Line_WR_EN is seen.
REQ-005 Miss_ADD  input  WIDTH_ADD  byte address of the missing instruction.
REQ-006 AXI_ARADDR  output  WIDTH_ADD  line-aligned burst start address.
REQ-007 AXI_ARLEN  output  8  burst length minus one, constant NUMBER_WORD-1.
REQ-008 AXI_ARVALID  output  1 / AXI_ARREADY  input  1  read-address handshake.
REQ-009 AXI_RDATA  input  WIDTH_DATA / AXI_RRESP  input  2 / AXI_RLAST  input  1 / AXI_RVALID  input  1  read-data beat.
REQ-010 AXI_RREADY  output  1  ready to accept a read-data beat.
REQ-011 Line_Data  output  WIDTH_DATA*NUMBER_WORD  assembled line; word k at bits [32k+31:32k].
REQ-012 Line_ADD  output  WIDTH_ADD  line-aligned address of Line_Data.
REQ-013 Line_WR_EN  output  1  single-cycle cache-fill strobe.
REQ-014 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 Err  output  1  sticky refill-error flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, ADDR, DATA, FILL.
REQ-017 In IDLE with Miss_Req=1, the block SHALL latch Miss_ADD with its low log2(NUMBER_WORD*WIDTH_DATA/8) bits cleared (5 bits at defaults), clear Err, clear the beat counter, and go to ADDR next cycle.
REQ-018 In ADDR, AXI_ARVALID SHALL be 1 and AXI_ARADDR SHALL equal the latched address, held stable until the cycle AXI_ARREADY=1; that cycle SHALL go to DATA.
REQ-019 In DATA, AXI_RREADY SHALL be 1; AXI_RREADY and AXI_ARVALID SHALL be 0 in every other state.
REQ-020 Each cycle with AXI_RVALID=1 in DATA SHALL write AXI_RDATA into word slot beat_cnt of the line buffer and increment beat_cnt (width log2(NUMBER_WORD)).
REQ-021 The beat with beat_cnt=NUMBER_WORD-1 SHALL end the burst; the next state SHALL be FILL if no error occurred during the burst, else IDLE.
REQ-022 Error SHALL be: AXI_RRESP!=0 on any beat, AXI_RLAST=1 on a beat other than the last, or AXI_RLAST=0 on the last beat; any error SHALL set Err to 1 at the end of the burst.
REQ-023 An early AXI_RLAST SHALL NOT terminate the burst; the FSM SHALL keep counting to NUMBER_WORD beats.
REQ-024 In FILL, Line_WR_EN SHALL be 1 for exactly one cycle with Line_Data and Line_ADD valid, then the FSM SHALL return to IDLE.
REQ-025 Line_Data and Line_ADD SHALL hold their values outside FILL until the next refill overwrites them.
REQ-026 Miss_Req and Miss_ADD changes while Busy=1 SHALL be ignored; Miss_Req still high in the cycle after FILL SHALL start a new refill.
REQ-027 Minimum latency Miss_Req accepted to Line_WR_EN SHALL be NUMBER_WORD+3 cycles (ARREADY and RVALID always high).
REQ-028 AXI_RVALID in IDLE, ADDR or FILL SHALL be ignored.

Reset
REQ-029 While RST=0, the FSM SHALL be IDLE and beat_cnt, Line_Data, Line_ADD, Line_WR_EN, AXI_ARVALID, AXI_RREADY, Busy and Err SHALL be 0; AXI_ARADDR SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abandon the refill immediately, with no Line_WR_EN on release.

Verification
REQ-031 Miss_ADD=0x0000_1234, ARREADY and RVALID always 1, RDATA=k for beat k, RLAST on beat 7 -> ARADDR=0x0000_1220, ARLEN=7, Line_WR_EN at cycle 11 after acceptance, Line_Data word k = k, Err=0.
REQ-032 ARREADY low for 4 cycles -> ARVALID held high, ARADDR stable for 5 cycles, then normal completion.
REQ-033 RVALID toggling 1,0,1,0 -> exactly 8 beats captured in order, Line_WR_EN one cycle after eighth beat.
REQ-034 RRESP=2'b10 on beat 3 -> all 8 beats consumed, no Line_WR_EN, Err=1, Busy=0; next Miss_Req clears Err.
REQ-035 RST pulsed low during beat 4 -> all outputs 0 immediately, no Line_WR_EN after release.
REQ-036 Miss_Req held high across two refills with Miss_ADD changed during the first -> second refill uses the address present at re-acceptance.

Source files
------------

// File: rtl/i_cache_refill_ctrl.sv
// i_cache_refill_ctrl
//   Fetches one instruction-cache line over an AXI read burst after a miss.
//   A miss address is line-aligned, issued on the AR channel as a single
//   NUMBER_WORD-beat INCR burst, and the beats are collected into a line
//   buffer. A clean burst is published with a one-cycle Line_WR_EN strobe.
//   A burst with a bad response or misplaced RLAST is still drained to
//   completion, then dropped with the sticky Err flag raised.
//
// Ports
//   CLK, RST            clock, asynchronous active-low reset
//   Miss_Req, Miss_ADD  miss request and byte address (sampled only in IDLE)
//   AXI_AR*             read-address channel (ARLEN fixed at NUMBER_WORD-1)
//   AXI_R*              read-data channel
//   Line_Data, Line_ADD assembled line and its aligned address (held until
//                       the next successful refill)
//   Line_WR_EN          single-cycle cache-fill strobe
//   Busy, Err           FSM-not-idle flag, sticky refill-error flag
module i_cache_refill_ctrl #(
  parameter int WIDTH_DATA  = 32,
  parameter int NUMBER_WORD = 8,
  parameter int WIDTH_ADD   = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              Miss_Req,
  input  logic [WIDTH_ADD-1:0]              Miss_ADD,
  output logic [WIDTH_ADD-1:0]              AXI_ARADDR,
  output logic [7:0]                        AXI_ARLEN,
  output logic                              AXI_ARVALID,
  input  logic                              AXI_ARREADY,
  input  logic [WIDTH_DATA-1:0]             AXI_RDATA,
  input  logic [1:0]                        AXI_RRESP,
  input  logic                              AXI_RLAST,
  input  logic                              AXI_RVALID,
  output logic                              AXI_RREADY,
  output logic [WIDTH_DATA*NUMBER_WORD-1:0] Line_Data,
  output logic [WIDTH_ADD-1:0]              Line_ADD,
  output logic                              Line_WR_EN,
  output logic                              Busy,
  output logic                              Err
);

  localparam int OFFSET_BITS = $clog2(NUMBER_WORD * WIDTH_DATA / 8);
  localparam int BEAT_W      = (NUMBER_WORD > 1) ? $clog2(NUMBER_WORD) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(NUMBER_WORD - 1);
  localparam logic [WIDTH_ADD-1:0] ALIGN_MASK =
    ~((WIDTH_ADD'(1) << OFFSET_BITS) - WIDTH_ADD'(1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FILL} state_t;

  state_t                    state_reg;
  logic [BEAT_W-1:0]         beat_cnt_reg;
  logic                      burst_err_reg;
  // The last word never needs storing: it is taken straight from AXI_RDATA
  // on the edge that publishes the line.
  logic [WIDTH_DATA-1:0]     line_buf [NUMBER_WORD-1];
  logic [WIDTH_DATA*NUMBER_WORD-1:0] line_next;

  logic beat_fire;
  logic last_beat;
  logic beat_err;

  assign AXI_ARLEN = 8'(NUMBER_WORD - 1);

  assign beat_fire = (state_reg == DATA) && AXI_RVALID;
  assign last_beat = (beat_cnt_reg == LAST_BEAT);
  // RLAST must appear exactly on the final beat; anywhere else is an error.
  assign beat_err  = (AXI_RRESP != 2'b00) || (AXI_RLAST != last_beat);

  generate
    for (genvar gi = 0; gi < NUMBER_WORD; gi++) begin : g_line_next
      if (gi < NUMBER_WORD - 1) begin : g_buf
        assign line_next[gi*WIDTH_DATA +: WIDTH_DATA] = line_buf[gi];
      end else begin : g_last
        assign line_next[gi*WIDTH_DATA +: WIDTH_DATA] = AXI_RDATA;
      end
    end
  endgenerate

  // Line buffer is pure data storage; its contents only matter once a
  // complete burst has overwritten every slot, so it carries no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUMBER_WORD - 1; i++) begin
      if (beat_fire && (beat_cnt_reg == BEAT_W'(i))) begin
        line_buf[i] <= AXI_RDATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      burst_err_reg <= 1'b0;
      AXI_ARADDR    <= '0;
      AXI_ARVALID   <= 1'b0;
      AXI_RREADY    <= 1'b0;
      Line_Data     <= '0;
      Line_ADD      <= '0;
      Line_WR_EN    <= 1'b0;
      Busy          <= 1'b0;
      Err           <= 1'b0;
    end else begin
      Line_WR_EN <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Miss_Req) begin
            AXI_ARADDR    <= Miss_ADD & ALIGN_MASK;
            AXI_ARVALID   <= 1'b1;
            Busy          <= 1'b1;
            Err           <= 1'b0;
            beat_cnt_reg  <= '0;
            burst_err_reg <= 1'b0;
            state_reg     <= ADDR;
          end
        end
        ADDR: begin
          if (AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (AXI_RVALID) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            if (last_beat) begin
              // Burst length is fixed by the beat count, never by RLAST.
              AXI_RREADY <= 1'b0;
              if (burst_err_reg || beat_err) begin
                Err       <= 1'b1;
                Busy      <= 1'b0;
                state_reg <= IDLE;
              end else begin
                Line_Data  <= line_next;
                Line_ADD   <= AXI_ARADDR;
                Line_WR_EN <= 1'b1;
                state_reg  <= FILL;
              end
            end else begin
              burst_err_reg <= burst_err_reg | beat_err;
            end
          end
        end
        FILL: begin
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          AXI_ARVALID <= 1'b0;
          AXI_RREADY  <= 1'b0;
          Busy        <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_cache_refill_ctrl.sv
module tb_i_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  miss_add;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         r_valid;
  logic         r_ready;
  logic [255:0] line_data;
  logic [31:0]  line_add;
  logic         line_wr_en;
  logic         busy;
  logic         err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  i_cache_refill_ctrl #(
    .WIDTH_DATA (32),
    .NUMBER_WORD(8),
    .WIDTH_ADD  (32)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .Miss_Req   (miss_req),
    .Miss_ADD   (miss_add),
    .AXI_ARADDR (ar_addr),
    .AXI_ARLEN  (ar_len),
    .AXI_ARVALID(ar_valid),
    .AXI_ARREADY(ar_ready),
    .AXI_RDATA  (r_data),
    .AXI_RRESP  (r_resp),
    .AXI_RLAST  (r_last),
    .AXI_RVALID (r_valid),
    .AXI_RREADY (r_ready),
    .Line_Data  (line_data),
    .Line_ADD   (line_add),
    .Line_WR_EN (line_wr_en),
    .Busy       (busy),
    .Err        (err)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a miss for one acceptance edge; Miss_Req is left high.
  task automatic accept(input logic [31:0] addr);
    miss_add = addr;
    miss_req = 1'b1;
    tick();
  endtask

  // Slave model for one refill, entered just after the acceptance edge.
  // Cycle numbering: the acceptance cycle is cycle 1, so the first sample
  // here (ADDR state) is cycle 2. Runs until Busy drops.
  task automatic serve(input logic [31:0] exp_addr, input int ar_wait,
                       input bit toggle, input int err_beat, input int rlast_beat,
                       input bit keep_req, input logic [31:0] base,
                       output int ar_hi, output bit ar_stable, output int wr_at,
                       output int wr_cnt, output int beats, output int b8_cyc,
                       output bit done);
    int  cyc;
    int  dcyc;
    bit  rv;
    bit  take;
    cyc = 2; dcyc = 0; ar_hi = 0; ar_stable = 1'b1; wr_at = -1;
    wr_cnt = 0; beats = 0; b8_cyc = -1; done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (ar_valid) begin
        ar_hi++;
        if (ar_addr !== exp_addr) ar_stable = 1'b0;
      end
      if (line_wr_en) begin
        wr_cnt++;
        if (wr_at < 0) wr_at = cyc;
        if (!keep_req) miss_req = 1'b0;
      end
      ar_ready = (ar_hi > ar_wait);
      if (r_ready) begin
        rv = toggle ? (dcyc % 2 == 0) : 1'b1;
        dcyc++;
      end else begin
        rv = 1'b1;  // RVALID outside DATA must be ignored
      end
      r_valid = rv;
      r_data  = base + 32'(beats);
      r_last  = (beats == rlast_beat);
      r_resp  = (beats == err_beat) ? 2'b10 : 2'b00;
      take    = r_ready && rv;
      if (take && beats == 7) b8_cyc = cyc;
      tick();
      cyc++;
      if (take) beats++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_req = 1'b0; miss_add = 32'h0; ar_ready = 1'b0;
    r_data = 32'h0; r_resp = 2'b00; r_last = 1'b0; r_valid = 1'b0;
    #2;
    total_cnt++;
    if ({busy, err, ar_valid, r_ready, line_wr_en} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {busy, err, ar_valid, r_ready, line_wr_en});
    end else pass_cnt++;
    total_cnt++;
    if (ar_addr !== 32'h0 || line_add !== 32'h0) begin
      $display("FAIL reset_addr: got araddr=%h line_add=%h expected 0", ar_addr, line_add);
    end else pass_cnt++;
    total_cnt++;
    if (line_data !== 256'h0) begin
      $display("FAIL reset_line_data: got %h expected 0", line_data);
    end else pass_cnt++;
    total_cnt++;
    if (ar_len !== 8'd7) begin
      $display("FAIL arlen: got %0d expected 7", ar_len);
    end else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    logic [255:0] exp_line;
    accept(32'h0000_1234);
    total_cnt++;
    if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_1220 || busy !== 1'b1) begin
      $display("FAIL basic_addr_phase: got arvalid=%b araddr=%h busy=%b expected 1 00001220 1", ar_valid, ar_addr, busy);
    end else pass_cnt++;
    serve(32'h0000_1220, 0, 1'b0, -1, 7, 1'b0, 32'h0, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (!done || wr_cnt !== 1 || wr_at !== 11) begin
      $display("FAIL basic_latency: got done=%0d wr_cnt=%0d wr_cycle=%0d expected 1 1 11", done, wr_cnt, wr_at);
    end else pass_cnt++;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'(k);
    total_cnt++;
    if (line_data !== exp_line || line_add !== 32'h0000_1220 || err !== 1'b0) begin
      $display("FAIL basic_line: got data=%h add=%h err=%b expected data=%h add=00001220 err=0", line_data, line_add, err, exp_line);
    end else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if (line_data !== exp_line || line_wr_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_hold: got data=%h wr_en=%b busy=%b expected %h 0 0", line_data, line_wr_en, busy, exp_line);
    end else pass_cnt++;
    $display("test_basic done: wr_cycle=%0d", wr_at);
  endtask

  task automatic test_ar_stall();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    logic [255:0] exp_line;
    accept(32'h0000_ABCD);
    serve(32'h0000_ABC0, 4, 1'b0, -1, 7, 1'b0, 32'h100, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (ar_hi !== 5 || st !== 1'b1) begin
      $display("FAIL ar_stall_hold: got arvalid_cycles=%0d stable=%0d expected 5 1", ar_hi, st);
    end else pass_cnt++;
    total_cnt++;
    if (!done || wr_cnt !== 1 || wr_at !== 15) begin
      $display("FAIL ar_stall_latency: got done=%0d wr_cnt=%0d wr_cycle=%0d expected 1 1 15", done, wr_cnt, wr_at);
    end else pass_cnt++;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h100 + 32'(k);
    total_cnt++;
    if (line_data !== exp_line || line_add !== 32'h0000_ABC0) begin
      $display("FAIL ar_stall_line: got data=%h add=%h expected %h 0000abc0", line_data, line_add, exp_line);
    end else pass_cnt++;
    $display("test_ar_stall done: wr_cycle=%0d", wr_at);
  endtask

  task automatic test_rvalid_toggle();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    logic [255:0] exp_line;
    accept(32'h0002_0040);
    serve(32'h0002_0040, 0, 1'b1, -1, 7, 1'b0, 32'h200, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (!done || beats !== 8 || wr_cnt !== 1) begin
      $display("FAIL toggle_beats: got done=%0d beats=%0d wr_cnt=%0d expected 1 8 1", done, beats, wr_cnt);
    end else pass_cnt++;
    total_cnt++;
    if (b8 !== 17 || wr_at !== 18) begin
      $display("FAIL toggle_timing: got beat8_cycle=%0d wr_cycle=%0d expected 17 18", b8, wr_at);
    end else pass_cnt++;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h200 + 32'(k);
    total_cnt++;
    if (line_data !== exp_line) begin
      $display("FAIL toggle_line: got %h expected %h", line_data, exp_line);
    end else pass_cnt++;
    $display("test_rvalid_toggle done: wr_cycle=%0d", wr_at);
  endtask

  task automatic test_rresp_error();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    logic [255:0] exp_line;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h200 + 32'(k);
    accept(32'h0000_3000);
    serve(32'h0000_3000, 0, 1'b0, 3, 7, 1'b0, 32'h900, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    miss_req = 1'b0;
    total_cnt++;
    if (!done || beats !== 8 || wr_cnt !== 0) begin
      $display("FAIL rresp_drain: got done=%0d beats=%0d wr_cnt=%0d expected 1 8 0", done, beats, wr_cnt);
    end else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL rresp_err: got err=%b busy=%b expected 1 0", err, busy);
    end else pass_cnt++;
    total_cnt++;
    if (line_data !== exp_line || line_add !== 32'h0002_0040) begin
      $display("FAIL rresp_keep_line: got data=%h add=%h expected %h 00020040", line_data, line_add, exp_line);
    end else pass_cnt++;
    tick();
    accept(32'h0000_5010);
    total_cnt++;
    if (err !== 1'b0) begin
      $display("FAIL rresp_err_clear: got err=%b expected 0", err);
    end else pass_cnt++;
    serve(32'h0000_5000, 0, 1'b0, -1, 7, 1'b0, 32'h500, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (!done || wr_cnt !== 1 || line_add !== 32'h0000_5000 || err !== 1'b0) begin
      $display("FAIL rresp_recover: got done=%0d wr_cnt=%0d add=%h err=%b expected 1 1 00005000 0", done, wr_cnt, line_add, err);
    end else pass_cnt++;
    $display("test_rresp_error done");
  endtask

  task automatic test_early_rlast();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    accept(32'h0000_6000);
    serve(32'h0000_6000, 0, 1'b0, -1, 2, 1'b0, 32'h600, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    miss_req = 1'b0;
    total_cnt++;
    if (!done || beats !== 8 || wr_cnt !== 0 || err !== 1'b1) begin
      $display("FAIL early_rlast: got done=%0d beats=%0d wr_cnt=%0d err=%b expected 1 8 0 1", done, beats, wr_cnt, err);
    end else pass_cnt++;
    tick();
    $display("test_early_rlast done");
  endtask

  task automatic test_midburst_reset();
    int wr_seen;
    int busy_seen;
    accept(32'h0000_7000);
    miss_req = 1'b0;
    ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b00; r_last = 1'b0;
    r_data = 32'h700;
    tick();  // ADDR -> DATA
    for (int k = 0; k < 4; k++) begin
      r_data = 32'h700 + 32'(k);
      tick();
    end
    r_data = 32'h704;  // beat 4 on the bus
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, err, ar_valid, r_ready, line_wr_en} !== 5'b0 || ar_addr !== 32'h0) begin
      $display("FAIL midburst_reset_flags: got flags=%b araddr=%h expected 00000 0", {busy, err, ar_valid, r_ready, line_wr_en}, ar_addr);
    end else pass_cnt++;
    total_cnt++;
    if (line_data !== 256'h0 || line_add !== 32'h0) begin
      $display("FAIL midburst_reset_line: got data=%h add=%h expected 0 0", line_data, line_add);
    end else pass_cnt++;
    tick();
    rst_n = 1'b1;
    wr_seen = 0; busy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (line_wr_en) wr_seen++;
      if (busy) busy_seen++;
    end
    total_cnt++;
    if (wr_seen !== 0 || busy_seen !== 0) begin
      $display("FAIL midburst_release: got wr_en_cycles=%0d busy_cycles=%0d expected 0 0", wr_seen, busy_seen);
    end else pass_cnt++;
    $display("test_midburst_reset done");
  endtask

  task automatic test_back_to_back();
    int ar_hi, wr_at, wr_cnt, beats, b8; bit st, done;
    accept(32'h0000_8004);
    miss_add = 32'h0000_4444;  // must be ignored while busy
    serve(32'h0000_8000, 0, 1'b0, -1, 7, 1'b1, 32'h800, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (!done || wr_cnt !== 1 || st !== 1'b1 || line_add !== 32'h0000_8000) begin
      $display("FAIL b2b_first: got done=%0d wr_cnt=%0d stable=%0d add=%h expected 1 1 1 00008000", done, wr_cnt, st, line_add);
    end else pass_cnt++;
    tick();  // IDLE with Miss_Req still high -> re-acceptance edge
    total_cnt++;
    if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_4440) begin
      $display("FAIL b2b_reaccept: got arvalid=%b araddr=%h expected 1 00004440", ar_valid, ar_addr);
    end else pass_cnt++;
    serve(32'h0000_4440, 0, 1'b0, -1, 7, 1'b0, 32'hA00, ar_hi, st, wr_at, wr_cnt, beats, b8, done);
    total_cnt++;
    if (!done || wr_cnt !== 1 || wr_at !== 11 || line_add !== 32'h0000_4440 || line_data[31:0] !== 32'hA00) begin
      $display("FAIL b2b_second: got done=%0d wr_cnt=%0d wr_cycle=%0d add=%h word0=%h expected 1 1 11 00004440 00000a00", done, wr_cnt, wr_at, line_add, line_data[31:0]);
    end else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_rvalid_toggle();
    test_rresp_error();
    test_early_rlast();
    test_midburst_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
